ariele_xbar_4x4: RTL and testbench
==================================

Name: ariele_xbar_4x4

Overview:
- 4-master x 4-slave crossbar for a simple req/ack/resp memory bus.
- Connects up to four bus masters (CPU cores, exercisers) to four memory-mapped slaves.
- Slave is selected by address bits [31:30].
- Each slave has a round-robin arbiter; read responses return to the issuing master in issue order.

Parameters:
TRANS_BUFSIZE, 4, max outstanding reads per master and per slave (response-tracking FIFO depth)

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  reset; synchronous, active-high
mN_req_i (N=0..3)  input  1  master N request valid
mN_ack_o  output  1  master N request accepted this cycle
mN_addr_bi  input  32  master N byte address
mN_we_i  input  1  1=write, 0=read
mN_wdata_bi  input  32  write data
mN_resp_o  output  1  read response valid (1-cycle pulse per read)
mN_rdata_bo  output  32  read data, valid when mN_resp_o=1
sM_req_o (M=0..3)  output  1  request to slave M
sM_ack_i  input  1  slave M accepts request
sM_addr_bo  output  32  address forwarded unmodified (full 32 bits)
sM_we_o  output  1  forwarded we
sM_wdata_bo  output  32  forwarded wdata
sM_resp_i  input  1  slave M read response valid
sM_rdata_bi  input  32  slave M read data

Behaviour:
- Bus protocol: master holds req/addr/we/wdata stable until ack. Handshake = req & ack in the same cycle. Writes produce no response. Each accepted read produces exactly one resp pulse, later. Neither side can stall resp.
- Decode: target slave = mN_addr_bi[31:30].
- Arbitration, per slave M:
  - Round-robin over eligible masters targeting M.
  - Priority pointer points to the highest-priority master; it resets to 0.
  - After a handshake, the pointer moves to (granted master + 1) mod 4.
  - Grant is combinational from pointer and eligible requests.
  - sM_req_o=1 iff a master is granted. The sM_addr/we/wdata muxes select the granted master; they are 0 when no grant.
  - mN_ack_o = sM_ack_i & (grant to N); combinational, zero added latency.
- Master eligibility (master N):
  - Per-master state: outstanding-read counter (0..TRANS_BUFSIZE) and current-slave register (2 bits).
  - If counter > 0, any request (read or write) whose target differs from current-slave is blocked: no grant, no ack.
  - A read is blocked if the counter == TRANS_BUFSIZE.
  - On a read handshake: counter +1 and current-slave := target.
  - On resp delivery: counter -1.
  - Simultaneous read handshake and resp: counter unchanged.
  - Consequence: a master's outstanding reads always target a single slave, so in-order slave responses give in-order delivery to the master.
- Slave response tracking (slave M): FIFO of master IDs, depth TRANS_BUFSIZE.
  - Push the granted master ID on a read handshake.
  - Pop on sM_resp_i.
  - Reads to M are ineligible while the FIFO is full. Writes are still allowed.
  - Push and pop in the same cycle are permitted when full: pop first, so the push is allowed.
- Response routing, combinational: mN_resp_o = OR over M of (sM_resp_i & FIFO_M head == N). mN_rdata_bo = rdata of that slave, else 0.
  - Slaves never respond to the same master in the same cycle (single-slave rule above).
  - sM_resp_i with an empty FIFO is dropped and does not underflow.
- Reset: all counters 0, FIFOs empty, pointers 0. All outputs 0 during reset: acks, resps, sM_req_o, data buses. Reset mid-transaction discards outstanding reads, and responses arriving after reset are dropped.
- No combinational path from mN_req_i to mN_resp_o.

Test Plan:
- Single write/read: after reset, m0 writes addr 0x40000010 data 0x40000010 → s1_req_o=1, s1_addr_bo=0x40000010. s1 ack → m0_ack_o in the same cycle. m0 reads the same address → m0_resp_o pulse, m0_rdata_bo=0x40000010; no resp on m1..m3.
- Contention: m0..m3 all read s2 continuously with slave ack always 1 → grants rotate 0,1,2,3,0; each master gets 1 ack per 4 cycles; responses reach the correct masters.
- Outstanding limit: m3 issues reads to s3; s3 acks but withholds resp → exactly 4 acks, then m3_ack_o=0 with m3_req_i=1. One s3_resp_i → one m3_resp_o and a 5th ack.
- Slave switch blocking: m1 has 2 reads outstanding to s0 and then requests s2 → no s2_req_o until both s0 responses are delivered; then granted.
- Data integrity: four masters write word value = address to disjoint ranges across all slaves, then read random addresses for 10000 cycles → every rdata == address; slave memories unchanged.
- Reset mid-op: assert rst_i with 3 reads outstanding → next cycle all outputs 0; after release, a new read completes normally; stale s*_resp_i pulses are ignored.

Source files
------------

// File: rtl/ariele_xbar_4x4.sv
// ariele_xbar_4x4: 4-master x 4-slave crossbar for a req/ack/resp memory bus.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   mN_req_i/mN_ack_o       master N request valid / accepted this cycle
//   mN_addr_bi, mN_we_i,
//   mN_wdata_bi             master N address, write enable, write data
//   mN_resp_o/mN_rdata_bo   read response pulse and its data to master N
//   sM_req_o/sM_ack_i       request to slave M / slave M accepts
//   sM_addr_bo, sM_we_o,
//   sM_wdata_bo             forwarded request fields (0 when no grant)
//   sM_resp_i/sM_rdata_bi   slave M read response and data
//
// The slave is selected by addr[31:30]. Each slave has a round-robin arbiter
// and a FIFO of master IDs so read responses are routed back in issue order.
// A master with reads outstanding may only talk to the slave holding them,
// which keeps its responses in order without any reorder buffer.
module ariele_xbar_4x4 #(
  parameter int TRANS_BUFSIZE = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  output logic        m0_ack_o,
  input  logic [31:0] m0_addr_bi,
  input  logic        m0_we_i,
  input  logic [31:0] m0_wdata_bi,
  output logic        m0_resp_o,
  output logic [31:0] m0_rdata_bo,
  input  logic        m1_req_i,
  output logic        m1_ack_o,
  input  logic [31:0] m1_addr_bi,
  input  logic        m1_we_i,
  input  logic [31:0] m1_wdata_bi,
  output logic        m1_resp_o,
  output logic [31:0] m1_rdata_bo,
  input  logic        m2_req_i,
  output logic        m2_ack_o,
  input  logic [31:0] m2_addr_bi,
  input  logic        m2_we_i,
  input  logic [31:0] m2_wdata_bi,
  output logic        m2_resp_o,
  output logic [31:0] m2_rdata_bo,
  input  logic        m3_req_i,
  output logic        m3_ack_o,
  input  logic [31:0] m3_addr_bi,
  input  logic        m3_we_i,
  input  logic [31:0] m3_wdata_bi,
  output logic        m3_resp_o,
  output logic [31:0] m3_rdata_bo,
  output logic        s0_req_o,
  input  logic        s0_ack_i,
  output logic [31:0] s0_addr_bo,
  output logic        s0_we_o,
  output logic [31:0] s0_wdata_bo,
  input  logic        s0_resp_i,
  input  logic [31:0] s0_rdata_bi,
  output logic        s1_req_o,
  input  logic        s1_ack_i,
  output logic [31:0] s1_addr_bo,
  output logic        s1_we_o,
  output logic [31:0] s1_wdata_bo,
  input  logic        s1_resp_i,
  input  logic [31:0] s1_rdata_bi,
  output logic        s2_req_o,
  input  logic        s2_ack_i,
  output logic [31:0] s2_addr_bo,
  output logic        s2_we_o,
  output logic [31:0] s2_wdata_bo,
  input  logic        s2_resp_i,
  input  logic [31:0] s2_rdata_bi,
  output logic        s3_req_o,
  input  logic        s3_ack_i,
  output logic [31:0] s3_addr_bo,
  output logic        s3_we_o,
  output logic [31:0] s3_wdata_bo,
  input  logic        s3_resp_i,
  input  logic [31:0] s3_rdata_bi
);

  localparam int CW = $clog2(TRANS_BUFSIZE + 1);
  localparam int PW = (TRANS_BUFSIZE > 1) ? $clog2(TRANS_BUFSIZE) : 1;

  logic [3:0]  m_req, m_we, s_ack, s_resp;
  logic [31:0] m_addr [4];
  logic [31:0] m_wdata [4];
  logic [31:0] s_rdata [4];

  assign m_req = {m3_req_i, m2_req_i, m1_req_i, m0_req_i};
  assign m_we  = {m3_we_i, m2_we_i, m1_we_i, m0_we_i};
  assign s_ack  = {s3_ack_i, s2_ack_i, s1_ack_i, s0_ack_i};
  assign s_resp = {s3_resp_i, s2_resp_i, s1_resp_i, s0_resp_i};
  assign m_addr  = '{m0_addr_bi, m1_addr_bi, m2_addr_bi, m3_addr_bi};
  assign m_wdata = '{m0_wdata_bi, m1_wdata_bi, m2_wdata_bi, m3_wdata_bi};
  assign s_rdata = '{s0_rdata_bi, s1_rdata_bi, s2_rdata_bi, s3_rdata_bi};

  // Per-master outstanding-read tracking
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [1:0]    cur_q [4];
  logic [1:0]    cur_d [4];
  // Per-slave arbitration pointer and master-ID response FIFO
  logic [1:0]    ptr_q [4];
  logic [1:0]    ptr_d [4];
  logic [1:0]    fifo_mem_q [4][TRANS_BUFSIZE];
  logic [1:0]    fifo_mem_d [4][TRANS_BUFSIZE];
  logic [PW-1:0] rd_q [4];
  logic [PW-1:0] rd_d [4];
  logic [PW-1:0] wr_q [4];
  logic [PW-1:0] wr_d [4];
  logic [CW-1:0] fcnt_q [4];
  logic [CW-1:0] fcnt_d [4];

  logic [3:0]  elig [4];
  logic [1:0]  gnt_idx [4];
  logic [1:0]  rr_idx;
  logic [3:0]  gnt_vld, hs, rd_push, resp_vld;
  logic [3:0]  m_ack, m_resp, m_rd_hs, s_req, s_we;
  logic [31:0] m_rdata [4];
  logic [31:0] s_addr [4];
  logic [31:0] s_wdata [4];

  // Eligibility and round-robin grant. A full slave FIFO still accepts a
  // read when a response pops it in the same cycle; the per-master limit
  // has no such exception.
  always_comb begin
    rr_idx = 2'd0;
    for (int m = 0; m < 4; m++) begin
      elig[m]    = 4'b0;
      gnt_vld[m] = 1'b0;
      gnt_idx[m] = 2'd0;
      for (int n = 0; n < 4; n++) begin
        elig[m][n] = m_req[n] && (m_addr[n][31:30] == 2'(m)) &&
                     ((cnt_q[n] == '0) || (cur_q[n] == 2'(m))) &&
                     (m_we[n] || ((cnt_q[n] != CW'(TRANS_BUFSIZE)) &&
                      ((fcnt_q[m] != CW'(TRANS_BUFSIZE)) || s_resp[m])));
      end
      // Scanning from lowest to highest priority leaves the highest winner.
      for (int k = 3; k >= 0; k--) begin
        rr_idx = ptr_q[m] + 2'(k);
        if (elig[m][rr_idx]) begin
          gnt_vld[m] = 1'b1;
          gnt_idx[m] = rr_idx;
        end
      end
    end
  end

  // Request forwarding, acks and response routing; all forced to 0 in reset.
  always_comb begin
    m_ack   = 4'b0;
    m_rd_hs = 4'b0;
    m_resp  = 4'b0;
    for (int n = 0; n < 4; n++) m_rdata[n] = 32'h0;
    for (int m = 0; m < 4; m++) begin
      s_req[m]    = gnt_vld[m] && !rst_i;
      hs[m]       = s_req[m] && s_ack[m];
      rd_push[m]  = hs[m] && !m_we[gnt_idx[m]];
      resp_vld[m] = s_resp[m] && (fcnt_q[m] != '0) && !rst_i;
      s_addr[m]   = s_req[m] ? m_addr[gnt_idx[m]] : 32'h0;
      s_wdata[m]  = s_req[m] ? m_wdata[gnt_idx[m]] : 32'h0;
      s_we[m]     = s_req[m] ? m_we[gnt_idx[m]] : 1'b0;
      for (int n = 0; n < 4; n++) begin
        if (hs[m] && (gnt_idx[m] == 2'(n))) begin
          m_ack[n]   = 1'b1;
          m_rd_hs[n] = !m_we[n];
        end
        if (resp_vld[m] && (fifo_mem_q[m][rd_q[m]] == 2'(n))) begin
          m_resp[n]  = 1'b1;
          m_rdata[n] = s_rdata[m];
        end
      end
    end
  end

  // Next-state for master counters, arbitration pointers and FIFOs.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      cnt_d[n] = cnt_q[n];
      cur_d[n] = cur_q[n];
      if (m_rd_hs[n]) cur_d[n] = m_addr[n][31:30];
      if (m_rd_hs[n] && !m_resp[n]) cnt_d[n] = cnt_q[n] + CW'(1);
      else if (!m_rd_hs[n] && m_resp[n] && (cnt_q[n] != '0)) cnt_d[n] = cnt_q[n] - CW'(1);
    end
    for (int m = 0; m < 4; m++) begin
      ptr_d[m]      = hs[m] ? (gnt_idx[m] + 2'd1) : ptr_q[m];
      fifo_mem_d[m] = fifo_mem_q[m];
      wr_d[m]       = wr_q[m];
      rd_d[m]       = rd_q[m];
      fcnt_d[m]     = fcnt_q[m];
      if (rd_push[m]) begin
        fifo_mem_d[m][wr_q[m]] = gnt_idx[m];
        wr_d[m] = (wr_q[m] == PW'(TRANS_BUFSIZE - 1)) ? '0 : wr_q[m] + PW'(1);
      end
      if (resp_vld[m]) begin
        rd_d[m] = (rd_q[m] == PW'(TRANS_BUFSIZE - 1)) ? '0 : rd_q[m] + PW'(1);
      end
      if (rd_push[m] && !resp_vld[m]) fcnt_d[m] = fcnt_q[m] + CW'(1);
      else if (!rd_push[m] && resp_vld[m]) fcnt_d[m] = fcnt_q[m] - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]  <= '0;
        cur_q[i]  <= 2'd0;
        ptr_q[i]  <= 2'd0;
        rd_q[i]   <= '0;
        wr_q[i]   <= '0;
        fcnt_q[i] <= '0;
        for (int j = 0; j < TRANS_BUFSIZE; j++) fifo_mem_q[i][j] <= 2'd0;
      end
    end else begin
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      ptr_q      <= ptr_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      fcnt_q     <= fcnt_d;
      fifo_mem_q <= fifo_mem_d;
    end
  end

  assign {m3_ack_o, m2_ack_o, m1_ack_o, m0_ack_o}     = m_ack;
  assign {m3_resp_o, m2_resp_o, m1_resp_o, m0_resp_o} = m_resp;
  assign m0_rdata_bo = m_rdata[0];
  assign m1_rdata_bo = m_rdata[1];
  assign m2_rdata_bo = m_rdata[2];
  assign m3_rdata_bo = m_rdata[3];
  assign {s3_req_o, s2_req_o, s1_req_o, s0_req_o} = s_req;
  assign {s3_we_o, s2_we_o, s1_we_o, s0_we_o}     = s_we;
  assign s0_addr_bo  = s_addr[0];
  assign s1_addr_bo  = s_addr[1];
  assign s2_addr_bo  = s_addr[2];
  assign s3_addr_bo  = s_addr[3];
  assign s0_wdata_bo = s_wdata[0];
  assign s1_wdata_bo = s_wdata[1];
  assign s2_wdata_bo = s_wdata[2];
  assign s3_wdata_bo = s_wdata[3];

endmodule

// File: tb/tb_ariele_xbar_4x4.sv
// tb_ariele_xbar_4x4: self-checking bench for ariele_xbar_4x4.
// Slave memories return the address itself for unwritten words and every
// write stores data equal to its address, so each read must return its own
// address. Expected read data is queued per master at the ack and popped
// when that master sees a response.
module tb_ariele_xbar_4x4;

  logic clk;
  logic rst;
  logic [3:0]  mreq, mwe, mack, mresp;
  logic [3:0]  sreq, swe, sack, sresp;
  logic [31:0] maddr [4];
  logic [31:0] mwdata [4];
  logic [31:0] mrdata [4];
  logic [31:0] saddr [4];
  logic [31:0] swdata [4];
  logic [31:0] srdata [4];

  int vectors;
  int miscompares;
  logic [31:0] exp_q [4][$];
  logic [31:0] spend [4][$];
  logic [31:0] mem [logic [31:0]];
  int resp_cnt [4];
  int budget [4];
  logic [3:0] force_resp;
  logic [3:0] last_ack;
  bit resp_rand;

  ariele_xbar_4x4 #(.TRANS_BUFSIZE(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(mreq[0]), .m0_ack_o(mack[0]), .m0_addr_bi(maddr[0]), .m0_we_i(mwe[0]),
    .m0_wdata_bi(mwdata[0]), .m0_resp_o(mresp[0]), .m0_rdata_bo(mrdata[0]),
    .m1_req_i(mreq[1]), .m1_ack_o(mack[1]), .m1_addr_bi(maddr[1]), .m1_we_i(mwe[1]),
    .m1_wdata_bi(mwdata[1]), .m1_resp_o(mresp[1]), .m1_rdata_bo(mrdata[1]),
    .m2_req_i(mreq[2]), .m2_ack_o(mack[2]), .m2_addr_bi(maddr[2]), .m2_we_i(mwe[2]),
    .m2_wdata_bi(mwdata[2]), .m2_resp_o(mresp[2]), .m2_rdata_bo(mrdata[2]),
    .m3_req_i(mreq[3]), .m3_ack_o(mack[3]), .m3_addr_bi(maddr[3]), .m3_we_i(mwe[3]),
    .m3_wdata_bi(mwdata[3]), .m3_resp_o(mresp[3]), .m3_rdata_bo(mrdata[3]),
    .s0_req_o(sreq[0]), .s0_ack_i(sack[0]), .s0_addr_bo(saddr[0]), .s0_we_o(swe[0]),
    .s0_wdata_bo(swdata[0]), .s0_resp_i(sresp[0]), .s0_rdata_bi(srdata[0]),
    .s1_req_o(sreq[1]), .s1_ack_i(sack[1]), .s1_addr_bo(saddr[1]), .s1_we_o(swe[1]),
    .s1_wdata_bo(swdata[1]), .s1_resp_i(sresp[1]), .s1_rdata_bi(srdata[1]),
    .s2_req_o(sreq[2]), .s2_ack_i(sack[2]), .s2_addr_bo(saddr[2]), .s2_we_o(swe[2]),
    .s2_wdata_bo(swdata[2]), .s2_resp_i(sresp[2]), .s2_rdata_bi(srdata[2]),
    .s3_req_o(sreq[3]), .s3_ack_i(sack[3]), .s3_addr_bo(saddr[3]), .s3_we_o(swe[3]),
    .s3_wdata_bo(swdata[3]), .s3_resp_i(sresp[3]), .s3_rdata_bi(srdata[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called around the negedge: scores responses, models the slaves for the
  // handshakes of this cycle, then moves to just after the next posedge and
  // drives the slave responses for the new cycle.
  task automatic tick();
    logic [31:0] e;
    for (int n = 0; n < 4; n++) begin
      last_ack[n] = mack[n];
      if (mresp[n]) begin
        vectors++;
        resp_cnt[n]++;
        if (exp_q[n].size() == 0) begin
          miscompares++;
          $display("[TB] FAIL resp_unexpected m%0d: got resp rdata=%h, required no resp", n, mrdata[n]);
        end else begin
          e = exp_q[n].pop_front();
          if (mrdata[n] !== e) begin
            miscompares++;
            $display("[TB] FAIL rdata m%0d: got %h, required %h", n, mrdata[n], e);
          end
        end
      end
      if (mack[n] && !mwe[n]) exp_q[n].push_back(maddr[n]);
    end
    for (int m = 0; m < 4; m++) begin
      if (sreq[m] && sack[m]) begin
        vectors++;
        if (saddr[m][31:30] !== 2'(m) || (swe[m] && swdata[m] !== saddr[m])) begin
          miscompares++;
          $display("[TB] FAIL slave_req s%0d: got addr=%h we=%b wdata=%h, required addr[31:30]=%0d and wdata=addr",
                   m, saddr[m], swe[m], swdata[m], m);
        end
        if (swe[m]) mem[saddr[m]] = swdata[m];
        else spend[m].push_back(mem.exists(saddr[m]) ? mem[saddr[m]] : saddr[m]);
      end
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 4; m++) begin
      sresp[m]  = 1'b0;
      srdata[m] = 32'h0;
      if (force_resp[m]) begin
        sresp[m]  = 1'b1;
        srdata[m] = 32'hDEAD_0000 | 32'(m);
      end else if (spend[m].size() > 0 && budget[m] > 0 &&
                   (!resp_rand || $urandom_range(0, 1) == 1)) begin
        sresp[m]  = 1'b1;
        srdata[m] = spend[m].pop_front();
        budget[m]--;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    tick();
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() == 0) break;
      cycle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mreq = 4'hF;
    mwe = 4'h0;
    sack = 4'hF;
    force_resp = 4'hF;
    sresp = 4'hF;
    for (int n = 0; n < 4; n++) begin
      maddr[n] = (32'(n) << 30) | 32'h10;
      mwdata[n] = maddr[n];
      srdata[n] = 32'hDEAD_0000;
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int n = 0; n < 4; n++) begin
        vectors++;
        if (mack[n] !== 1'b0 || mresp[n] !== 1'b0 || mrdata[n] !== 32'h0) begin
          miscompares++;
          $display("[TB] FAIL reset_master m%0d: got ack=%b resp=%b rdata=%h, required all 0", n, mack[n], mresp[n], mrdata[n]);
        end
      end
      for (int m = 0; m < 4; m++) begin
        vectors++;
        if (sreq[m] !== 1'b0 || saddr[m] !== 32'h0 || swe[m] !== 1'b0 || swdata[m] !== 32'h0) begin
          miscompares++;
          $display("[TB] FAIL reset_slave s%0d: got req=%b addr=%h we=%b wdata=%h, required all 0", m, sreq[m], saddr[m], swe[m], swdata[m]);
        end
      end
      tick();
    end
    rst = 1'b0;
    mreq = 4'h0;
    sack = 4'h0;
    force_resp = 4'h0;
    sresp = 4'h0;
    for (int i = 0; i < 4; i++) begin
      exp_q[i].delete();
      spend[i].delete();
    end
    cycle();
  endtask

  task automatic test_single_write_read();
    int r0 [4];
    sack = 4'b0000;
    mreq = 4'b0001;
    mwe[0] = 1'b1;
    maddr[0] = 32'h4000_0010;
    mwdata[0] = 32'h4000_0010;
    @(negedge clk);
    vectors++;
    if (sreq !== 4'b0010 || saddr[1] !== 32'h4000_0010 || swe[1] !== 1'b1 ||
        swdata[1] !== 32'h4000_0010 || mack[0] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_fwd: got sreq=%b s1_addr=%h we=%b wdata=%h m0_ack=%b, required 0010 40000010 1 40000010 0",
               sreq, saddr[1], swe[1], swdata[1], mack[0]);
    end
    sack[1] = 1'b1;
    #1;
    vectors++;
    if (mack !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL single_write_ack: got mack=%b, required 0001", mack);
    end
    tick();
    mwe[0] = 1'b0;
    for (int n = 0; n < 4; n++) r0[n] = resp_cnt[n];
    @(negedge clk);
    vectors++;
    if (mack !== 4'b0001 || mresp !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL single_read_ack: got mack=%b mresp=%b, required 0001 0000", mack, mresp);
    end
    tick();
    mreq = 4'b0000;
    drain(10);
    vectors++;
    if (resp_cnt[0] - r0[0] != 1 || resp_cnt[1] != r0[1] || resp_cnt[2] != r0[2] || resp_cnt[3] != r0[3]) begin
      miscompares++;
      $display("[TB] FAIL single_resp_count: got m0..m3 resps %0d %0d %0d %0d, required 1 0 0 0",
               resp_cnt[0] - r0[0], resp_cnt[1] - r0[1], resp_cnt[2] - r0[2], resp_cnt[3] - r0[3]);
    end
  endtask

  task automatic test_contention();
    int k [4];
    logic [3:0] expv;
    sack = 4'b0100;
    mreq = 4'hF;
    mwe = 4'h0;
    for (int n = 0; n < 4; n++) begin
      k[n] = 0;
      maddr[n] = 32'h8000_0000 | (32'(n) << 8);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      expv = 4'b0001 << (i % 4);
      vectors++;
      if (mack !== expv) begin
        miscompares++;
        $display("[TB] FAIL contention_grant cycle %0d: got mack=%b, required %b", i, mack, expv);
      end
      tick();
      for (int n = 0; n < 4; n++) begin
        if (last_ack[n]) begin
          k[n]++;
          maddr[n] = 32'h8000_0000 | (32'(n) << 8) | (32'(k[n]) << 2);
        end
      end
    end
    mreq = 4'h0;
    drain(20);
    for (int n = 0; n < 4; n++) begin
      vectors++;
      if (exp_q[n].size() != 0) begin
        miscompares++;
        $display("[TB] FAIL contention_drain m%0d: got %0d pending, required 0", n, exp_q[n].size());
      end
    end
  endtask

  task automatic test_outstanding_limit();
    int k;
    int acks;
    int r0;
    logic expv;
    k = 0;
    acks = 0;
    sack = 4'b1000;
    budget[3] = 0;
    mreq = 4'b1000;
    mwe[3] = 1'b0;
    maddr[3] = 32'hC000_0000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      expv = (i < 4);
      vectors++;
      if (mack[3] !== expv) begin
        miscompares++;
        $display("[TB] FAIL limit_ack cycle %0d: got m3_ack=%b, required %b", i, mack[3], expv);
      end
      tick();
      if (last_ack[3]) begin
        k++;
        acks++;
        maddr[3] = 32'hC000_0000 | (32'(k) << 2);
      end
    end
    vectors++;
    if (acks != 4) begin
      miscompares++;
      $display("[TB] FAIL limit_ack_count: got %0d, required 4", acks);
    end
    budget[3] = 1;
    acks = 0;
    r0 = resp_cnt[3];
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (last_ack[3]) begin
        k++;
        acks++;
        maddr[3] = 32'hC000_0000 | (32'(k) << 2);
      end
    end
    vectors++;
    if (resp_cnt[3] - r0 != 1 || acks != 1) begin
      miscompares++;
      $display("[TB] FAIL limit_release: got resps=%0d acks=%0d, required 1 1", resp_cnt[3] - r0, acks);
    end
    budget[3] = 1000000;
    mreq = 4'h0;
    drain(40);
    vectors++;
    if (exp_q[3].size() != 0) begin
      miscompares++;
      $display("[TB] FAIL limit_drain: got %0d pending, required 0", exp_q[3].size());
    end
  endtask

  task automatic test_slave_switch();
    int acks;
    int base;
    bit granted;
    acks = 0;
    granted = 1'b0;
    sack = 4'b0101;
    budget[0] = 0;
    mreq = 4'b0010;
    mwe[1] = 1'b0;
    maddr[1] = 32'h0000_0100;
    for (int i = 0; i < 6 && acks < 2; i++) begin
      cycle();
      if (last_ack[1]) begin
        acks++;
        maddr[1] = 32'h0000_0100 | (32'(acks) << 2);
      end
    end
    vectors++;
    if (acks != 2) begin
      miscompares++;
      $display("[TB] FAIL switch_setup: got %0d acks, required 2", acks);
    end
    maddr[1] = 32'h8000_0100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (sreq[2] !== 1'b0 || mack[1] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL switch_blocked cycle %0d: got s2_req=%b m1_ack=%b, required 0 0", i, sreq[2], mack[1]);
      end
      tick();
    end
    base = resp_cnt[1];
    budget[0] = 1000000;
    for (int i = 0; i < 12 && !granted; i++) begin
      @(negedge clk);
      if (sreq[2]) begin
        granted = 1'b1;
        vectors++;
        if (resp_cnt[1] - base != 2 || mack[1] !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL switch_grant: got %0d s0 resps before s2 grant, m1_ack=%b, required 2 1", resp_cnt[1] - base, mack[1]);
        end
      end
      tick();
    end
    if (!granted) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL switch_timeout: got no s2 grant, required grant after s0 drain");
    end
    mreq = 4'h0;
    drain(20);
    vectors++;
    if (exp_q[1].size() != 0) begin
      miscompares++;
      $display("[TB] FAIL switch_drain: got %0d pending, required 0", exp_q[1].size());
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    int r0;
    bit acked;
    acks = 0;
    acked = 1'b0;
    sack = 4'b0010;
    budget[1] = 0;
    mreq = 4'b0100;
    mwe[2] = 1'b0;
    maddr[2] = 32'h4000_0100;
    for (int i = 0; i < 8 && acks < 3; i++) begin
      cycle();
      if (last_ack[2]) begin
        acks++;
        maddr[2] = 32'h4000_0100 | (32'(acks) << 2);
      end
    end
    vectors++;
    if (acks != 3) begin
      miscompares++;
      $display("[TB] FAIL rstmid_setup: got %0d acks, required 3", acks);
    end
    rst = 1'b1;
    sack = 4'hF;
    force_resp = 4'hF;
    sresp = 4'hF;
    for (int m = 0; m < 4; m++) srdata[m] = 32'hDEAD_BEEF;
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      vectors++;
      if (mack[n] !== 1'b0 || mresp[n] !== 1'b0 || mrdata[n] !== 32'h0) begin
        miscompares++;
        $display("[TB] FAIL rstmid_master m%0d: got ack=%b resp=%b rdata=%h, required all 0", n, mack[n], mresp[n], mrdata[n]);
      end
    end
    for (int m = 0; m < 4; m++) begin
      vectors++;
      if (sreq[m] !== 1'b0 || saddr[m] !== 32'h0 || swe[m] !== 1'b0 || swdata[m] !== 32'h0) begin
        miscompares++;
        $display("[TB] FAIL rstmid_slave s%0d: got req=%b addr=%h we=%b wdata=%h, required all 0", m, sreq[m], saddr[m], swe[m], swdata[m]);
      end
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      exp_q[i].delete();
      spend[i].delete();
    end
    rst = 1'b0;
    mreq = 4'h0;
    force_resp = 4'b0010;
    sresp = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (mresp !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL rstmid_stale: got mresp=%b, required 0000", mresp);
      end
      tick();
    end
    force_resp = 4'h0;
    sresp = 4'h0;
    budget[1] = 1000000;
    sack = 4'b0010;
    r0 = resp_cnt[2];
    mreq = 4'b0100;
    maddr[2] = 32'h4000_0200;
    for (int i = 0; i < 6 && !acked; i++) begin
      cycle();
      if (last_ack[2]) acked = 1'b1;
    end
    mreq = 4'h0;
    for (int i = 0; i < 6 && resp_cnt[2] == r0; i++) cycle();
    vectors++;
    if (!acked || resp_cnt[2] - r0 != 1) begin
      miscompares++;
      $display("[TB] FAIL rstmid_new_read: got acked=%b resps=%0d, required 1 1", acked, resp_cnt[2] - r0);
    end
  endtask

  task automatic test_data_integrity();
    int widx [4];
    bit pend [4];
    bit done;
    int wm;
    int ww;
    resp_rand = 1'b0;
    mwe = 4'hF;
    for (int n = 0; n < 4; n++) widx[n] = 0;
    for (int c = 0; c < 3000; c++) begin
      done = 1'b1;
      for (int n = 0; n < 4; n++) begin
        if (widx[n] < 16) begin
          done = 1'b0;
          wm = widx[n] / 4;
          ww = widx[n] % 4;
          mreq[n] = 1'b1;
          maddr[n] = (32'(wm) << 30) | (32'(n) << 6) | (32'(ww) << 2);
          mwdata[n] = maddr[n];
        end else begin
          mreq[n] = 1'b0;
        end
      end
      if (done) break;
      for (int m = 0; m < 4; m++) sack[m] = ($urandom_range(0, 3) != 0);
      cycle();
      for (int n = 0; n < 4; n++) if (last_ack[n]) widx[n]++;
    end
    vectors++;
    if (widx[0] + widx[1] + widx[2] + widx[3] != 64) begin
      miscompares++;
      $display("[TB] FAIL integrity_writes: got %0d writes, required 64", widx[0] + widx[1] + widx[2] + widx[3]);
    end
    resp_rand = 1'b1;
    mwe = 4'h0;
    for (int n = 0; n < 4; n++) pend[n] = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      for (int n = 0; n < 4; n++) begin
        if (!pend[n] && $urandom_range(0, 3) != 0) begin
          pend[n] = 1'b1;
          maddr[n] = (32'($urandom_range(0, 3)) << 30) | (32'($urandom_range(0, 3)) << 6) |
                     (32'($urandom_range(0, 3)) << 2);
          mwdata[n] = 32'h0;
        end
        mreq[n] = pend[n];
      end
      for (int m = 0; m < 4; m++) sack[m] = ($urandom_range(0, 3) != 0);
      cycle();
      for (int n = 0; n < 4; n++) if (last_ack[n]) pend[n] = 1'b0;
    end
    mreq = 4'h0;
    drain(400);
    for (int n = 0; n < 4; n++) begin
      vectors++;
      if (exp_q[n].size() != 0) begin
        miscompares++;
        $display("[TB] FAIL integrity_drain m%0d: got %0d pending, required 0", n, exp_q[n].size());
      end
    end
    vectors++;
    if (mem.num() < 64) begin
      miscompares++;
      $display("[TB] FAIL integrity_mem_size: got %0d words, required at least 64", mem.num());
    end
    foreach (mem[a]) begin
      vectors++;
      if (mem[a] !== a) begin
        miscompares++;
        $display("[TB] FAIL integrity_mem %h: got %h, required %h", a, mem[a], a);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    mreq = 4'h0;
    mwe = 4'h0;
    sack = 4'h0;
    sresp = 4'h0;
    force_resp = 4'h0;
    last_ack = 4'h0;
    resp_rand = 1'b0;
    for (int i = 0; i < 4; i++) begin
      maddr[i] = 32'h0;
      mwdata[i] = 32'h0;
      srdata[i] = 32'h0;
      resp_cnt[i] = 0;
      budget[i] = 1000000;
    end
    test_reset();
    test_single_write_read();
    test_contention();
    test_outstanding_limit();
    test_slave_switch();
    test_reset_mid();
    test_data_integrity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
